// File: rtl/k64_spi_slave_pkg.sv
// Shared constants and types for the K64 SPI slave.
package k64_spi_pkg;

    localparam int unsigned DataWDef  = 8;
    localparam logic [7:0]  DummyDef  = 8'h00;
    localparam int unsigned SyncDepth = 2;

    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

endpackage

// File: rtl/k64_spi_slave_if.sv
// Byte-stream side of the K64 SPI slave: TX offer, RX strobe and status pulses.
interface k64_spi_slave_if #(
    parameter int unsigned DataW = 8
);

    logic [DataW-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [DataW-1:0] rx_data;
    logic             rx_valid;
    logic             tx_underrun;
    logic             frame_abort;
    logic             busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

endinterface

// File: rtl/k64_spi_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus rise/fall detection.
module spi_sync_edge
    import k64_spi_pkg::*;
#(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncDepth-1:0] sync_q;
    logic                 prev_q;

    // Synchroniser chain followed by one extra flop holding the previous level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {SyncDepth{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], d_i};
            prev_q <= sync_q[SyncDepth-1];
        end
    end

    assign level_o = sync_q[SyncDepth-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/k64_spi_slave.sv
// SPI mode-0 slave: oversampled pins, MOSI deserialiser, one-deep TX buffer onto MISO.
module k64_spi_slave
    import k64_spi_pkg::*;
#(
    parameter int unsigned     DataW = DataWDef,
    parameter logic [DataW-1:0] Dummy = DataW'(DummyDef)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            spi_cs_n_i,
    input  logic            spi_sclk_i,
    input  logic            spi_mosi_i,
    output logic            spi_miso_o,
    output logic            spi_miso_oe_o,
    k64_spi_slave_if.slave  app_io
);

    localparam int unsigned CntW = $clog2(DataW);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.ResetVal(1'b1)) u_sync_cs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spi_cs_n_i),
        .level_o(cs_level),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spi_sclk_i),
        .level_o(sclk_level),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spi_mosi_i),
        .level_o(mosi_level),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    spi_state_e       state_q, state_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DataW-1:0] tx_shift_q, tx_shift_d;
    logic [DataW-1:0] rx_shift_q, rx_shift_d;
    logic [DataW-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             load_arm_q, load_arm_d;
    logic [DataW-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;
    logic             abort_q, abort_d;
    logic             load;

    // FSM, shift registers and TX holding buffer next-state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_arm_d  = load_arm_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    load       = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    load_arm_d = 1'b0;
                end
            end
            StActive: begin
                // CS rise wins over any coincident SCLK edge.
                if (cs_rise) begin
                    state_d    = StIdle;
                    abort_d    = (bit_cnt_q != '0);
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                    load_arm_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DataW-2:0], mosi_level};
                    if (bit_cnt_q == CntW'(DataW - 1)) begin
                        rx_data_d  = {rx_shift_q[DataW-2:0], mosi_level};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        load_arm_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (load_arm_q) begin
                        load       = 1'b1;
                        load_arm_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DataW-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = Dummy;
                underrun_d = 1'b1;
            end
        end

        // Acceptance coinciding with a load is stored for the following load.
        if (app_io.tx_valid && !hold_full_q) begin
            hold_d      = app_io.tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            load_arm_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            load_arm_q  <= load_arm_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign spi_miso_oe_o      = ~cs_level;
    assign spi_miso_o         = ~cs_level & tx_shift_q[DataW-1];
    assign app_io.tx_ready    = ~hold_full_q;
    assign app_io.rx_data     = rx_data_q;
    assign app_io.rx_valid    = rx_valid_q;
    assign app_io.tx_underrun = underrun_q;
    assign app_io.frame_abort = abort_q;
    assign app_io.busy        = ~cs_level;

endmodule
